// File: rtl/sdram_bus_pkg.sv
// Shared definitions for the SDRAM BIST master: bus strobe encodings, the
// controller state type and the test pattern generator.
package sdram_bus_pkg;

    localparam logic [3:0] WSTRB_WRITE = 4'hF;
    localparam logic [3:0] WSTRB_READ  = 4'h0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        RD_REQ = 2'd2,
        DONE   = 2'd3
    } bist_state_e;

    // Word index in the upper half, its complement in the lower half, so
    // every address line and both polarities of each data bit get exercised.
    function automatic logic [31:0] bist_pattern(input logic [15:0] k,
                                                 input logic [31:0] seed,
                                                 input logic        pass);
        logic [31:0] p;
        p = {k, ~k} ^ seed;
        return pass ? ~p : p;
    endfunction

endpackage

// File: rtl/sdram_bist_if.sv
// Valid/ready request bus between the BIST master and sys_sdram.
interface sdram_bist_if;
    logic        o_sys_data_valid;
    logic        i_sys_sdram_ready;
    logic [31:0] o_sys_addr;
    logic [31:0] o_sys_data_to_sdram;
    logic [3:0]  o_sys_write_str;
    logic [31:0] i_sys_data_from_sdram;

    modport master (
        output o_sys_data_valid, o_sys_addr, o_sys_data_to_sdram, o_sys_write_str,
        input  i_sys_sdram_ready, i_sys_data_from_sdram
    );

    modport slave (
        input  o_sys_data_valid, o_sys_addr, o_sys_data_to_sdram, o_sys_write_str,
        output i_sys_sdram_ready, i_sys_data_from_sdram
    );
endinterface

// File: rtl/bist_timeout_cnt.sv
// Per-request wait counter; expired_o rises in the TIMEOUT-th cycle of an
// outstanding request and holds until the next clear.
module bist_timeout_cnt #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sdram_bist.sv
// SDRAM built-in self-test master: two write/read-compare passes over a word
// region, reporting pass/fail, error count, first failure and bus timeout.
module sdram_bist
    import sdram_bus_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [31:0]         i_seed,
    sdram_bist_if.master        sys_bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic                o_timeout,
    output logic [15:0]         o_err_count,
    output logic [31:0]         o_fail_addr,
    output logic [31:0]         o_fail_data
);
    localparam logic [23:0] LAST_K = 24'(NUM_WORDS - 1);

    bist_state_e state_q, state_d;
    logic [23:0] k_q, k_d;
    logic        pass_q, pass_d;
    logic [31:0] seed_q, seed_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  str_q, str_d;
    logic [15:0] err_q, err_d;
    logic [31:0] fail_addr_q, fail_addr_d;
    logic [31:0] fail_data_q, fail_data_d;
    logic        ok_q, ok_d;
    logic        timeout_q, timeout_d;

    logic        tmr_clear;
    logic        tmr_expired;
    logic        hit;
    logic        last_word;
    logic [31:0] exp_word;

    assign hit       = valid_q && sys_bus.i_sys_sdram_ready;
    assign last_word = (k_q == LAST_K);
    assign exp_word  = bist_pattern(k_q[15:0], seed_q, pass_q);

    bist_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmr (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .clear_i  (tmr_clear),
        .en_i     (valid_q),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        pass_d      = pass_q;
        seed_d      = seed_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        str_d       = str_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        ok_d        = ok_q;
        timeout_d   = timeout_q;
        tmr_clear   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    seed_d      = i_seed;
                    ok_d        = 1'b0;
                    timeout_d   = 1'b0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    k_d         = '0;
                    pass_d      = 1'b0;
                    state_d     = WR_REQ;
                end
            end
            WR_REQ, RD_REQ: begin
                // valid_q low here is the mandatory idle cycle between requests
                if (!valid_q) begin
                    valid_d   = 1'b1;
                    addr_d    = ADDR_BASE + {6'b0, k_q, 2'b00};
                    wdata_d   = (state_q == WR_REQ) ? exp_word : 32'h0;
                    str_d     = (state_q == WR_REQ) ? WSTRB_WRITE : WSTRB_READ;
                    tmr_clear = 1'b1;
                end else if (hit) begin
                    valid_d = 1'b0;
                    if (state_q == RD_REQ &&
                        sys_bus.i_sys_data_from_sdram != exp_word) begin
                        if (err_q == '0) begin
                            fail_addr_d = addr_q;
                            fail_data_d = sys_bus.i_sys_data_from_sdram;
                        end
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                    end
                    if (last_word) begin
                        k_d = '0;
                        if (state_q == WR_REQ) begin
                            state_d = RD_REQ;
                        end else if (!pass_q) begin
                            pass_d  = 1'b1;
                            state_d = WR_REQ;
                        end else begin
                            ok_d    = (err_d == '0);
                            state_d = DONE;
                        end
                    end else begin
                        k_d = k_q + 24'd1;
                    end
                end else if (tmr_expired) begin
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                    ok_d      = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            pass_q      <= 1'b0;
            seed_q      <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            str_q       <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            ok_q        <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            pass_q      <= pass_d;
            seed_q      <= seed_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            str_q       <= str_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            ok_q        <= ok_d;
            timeout_q   <= timeout_d;
        end
    end

    assign sys_bus.o_sys_data_valid    = valid_q;
    assign sys_bus.o_sys_addr          = addr_q;
    assign sys_bus.o_sys_data_to_sdram = wdata_q;
    assign sys_bus.o_sys_write_str     = str_q;

    assign o_busy      = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign o_done      = (state_q == DONE);
    assign o_pass      = ok_q;
    assign o_timeout   = timeout_q;
    assign o_err_count = err_q;
    assign o_fail_addr = fail_addr_q;
    assign o_fail_data = fail_data_q;
endmodule

// File: tb/tb_sdram_bist.sv
// Self-checking bench for sdram_bist: memory-model responder, request
// scoreboard and a pass/word-level reference model of the whole test.
module tb_sdram_bist;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam int          NW_A   = 8;
    localparam int          TO     = 16;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  str;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [31:0] seed;
        int          lat;
        int          corrupt;
        int          hang;
        int          poke;
        int          exp_nreq;
        logic        exp_pass;
        logic        exp_to;
        logic [15:0] exp_err;
        logic [31:0] exp_faddr;
        logic [31:0] exp_fdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [31:0] seed_a = '0, seed_b = '0;
    logic        busy_a, done_a, pass_a, to_a;
    logic        busy_b, done_b, pass_b, to_b;
    logic [15:0] err_a, err_b;
    logic [31:0] faddr_a, fdata_a, faddr_b, fdata_b;

    sdram_bist_if bus_a ();
    sdram_bist_if bus_b ();

    sdram_bist #(.ADDR_BASE(BASE_A), .NUM_WORDS(NW_A), .TIMEOUT(TO)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_seed(seed_a), .sys_bus(bus_a),
        .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a), .o_timeout(to_a),
        .o_err_count(err_a), .o_fail_addr(faddr_a), .o_fail_data(fdata_a)
    );

    sdram_bist #(.ADDR_BASE(BASE_B), .NUM_WORDS(1), .TIMEOUT(TO)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_seed(seed_b), .sys_bus(bus_b),
        .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b), .o_timeout(to_b),
        .o_err_count(err_b), .o_fail_addr(faddr_b), .o_fail_data(fdata_b)
    );

    int checks = 0;
    int errors = 0;

    int lat_a = 1, hang_a = -1, served_a = 0, wcnt_a = 0, run_a = 0;
    int stab_err = 0, gap_err = 0;
    logic        corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;
    logic [31:0] mem_a [logic [31:0]];
    req_t        log_q[$];
    req_t        exp_q[$];
    req_t        cur_a;

    int          served_b = 0, addr_err_b = 0;
    logic [31:0] mem_b = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int k, input logic [31:0] s, input int p);
        logic [31:0] lo, w;
        lo = 32'(k) & 32'h0000_FFFF;
        w  = ((lo << 16) | (32'h0000_FFFF - lo)) ^ s;
        return (p != 0) ? ~w : w;
    endfunction

    // Reference: walk both passes word by word, build the request list and the final status.
    task automatic model(inout vec_t v, input logic [31:0] base, input int nw);
        int   n;
        bit   stop;
        logic [31:0] w, a;
        exp_q.delete();
        n = 0; stop = 0;
        v.exp_err = '0; v.exp_faddr = '0; v.exp_fdata = '0; v.exp_to = 1'b0;
        for (int p = 0; p < 2 && !stop; p++)
            for (int ph = 0; ph < 2 && !stop; ph++)
                for (int k = 0; k < nw && !stop; k++) begin
                    if (n == v.hang) begin
                        stop = 1; v.exp_to = 1'b1;
                    end else begin
                        w = pat(k, v.seed, p);
                        a = base + 32'(k) * 32'd4;
                        if (ph == 0) exp_q.push_back('{a, 4'hF, w});
                        else begin
                            exp_q.push_back('{a, 4'h0, 32'h0});
                            if (k == v.corrupt) begin
                                if (v.exp_err == 0) begin
                                    v.exp_faddr = a; v.exp_fdata = w ^ 32'h1;
                                end
                                v.exp_err = v.exp_err + 16'd1;
                            end
                        end
                        n++;
                    end
                end
        v.exp_nreq = n;
        v.exp_pass = (v.exp_err == 0) && !v.exp_to;
    endtask

    initial begin : resp_a
        logic [31:0] rd;
        bus_a.i_sys_sdram_ready = 1'b0;
        bus_a.i_sys_data_from_sdram = '0;
        forever begin
            @(posedge clk); #1;
            if (bus_a.i_sys_sdram_ready) begin
                bus_a.i_sys_sdram_ready = 1'b0;
                wcnt_a = 0;
                if (bus_a.o_sys_data_valid) gap_err++;
            end else if (bus_a.o_sys_data_valid) begin
                wcnt_a++;
                run_a = wcnt_a;
                if (wcnt_a == 1)
                    cur_a = '{bus_a.o_sys_addr, bus_a.o_sys_write_str, bus_a.o_sys_data_to_sdram};
                else if (cur_a.addr !== bus_a.o_sys_addr || cur_a.str !== bus_a.o_sys_write_str ||
                         cur_a.data !== bus_a.o_sys_data_to_sdram)
                    stab_err++;
                if (served_a != hang_a && wcnt_a >= lat_a) begin
                    rd = '0;
                    if (cur_a.str == 4'hF) mem_a[cur_a.addr] = cur_a.data;
                    else begin
                        if (mem_a.exists(cur_a.addr)) rd = mem_a[cur_a.addr];
                        if (corrupt_en && cur_a.addr == corrupt_addr) rd = rd ^ 32'h1;
                    end
                    bus_a.i_sys_data_from_sdram = rd;
                    bus_a.i_sys_sdram_ready = 1'b1;
                    log_q.push_back(cur_a);
                    served_a++;
                end
            end else begin
                wcnt_a = 0;
            end
        end
    end

    initial begin : resp_b
        bus_b.i_sys_sdram_ready = 1'b0;
        bus_b.i_sys_data_from_sdram = '0;
        forever begin
            @(posedge clk); #1;
            if (bus_b.i_sys_sdram_ready) bus_b.i_sys_sdram_ready = 1'b0;
            else if (bus_b.o_sys_data_valid) begin
                if (bus_b.o_sys_addr !== BASE_B) addr_err_b++;
                if (bus_b.o_sys_write_str == 4'hF) mem_b = bus_b.o_sys_data_to_sdram;
                bus_b.i_sys_data_from_sdram = mem_b;
                bus_b.i_sys_sdram_ready = 1'b1;
                served_b++;
            end
        end
    end

    task automatic run_test(input int idx, input vec_t v);
        vec_t e;
        int   cyc, mism;
        string t;
        e = v;
        model(e, BASE_A, NW_A);
        t = $sformatf("v%0d", idx);
        lat_a = e.lat; hang_a = e.hang;
        corrupt_en = (e.corrupt >= 0);
        corrupt_addr = BASE_A + 32'(e.corrupt) * 32'd4;
        served_a = 0; log_q.delete(); mem_a.delete();
        stab_err = 0; gap_err = 0; run_a = 0;
        @(posedge clk); #1;
        seed_a = e.seed; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        while (!done_a && cyc < 4000) begin
            if (e.poke != 0 && cyc == 20) begin
                start_a = 1'b1; seed_a = ~e.seed;
            end else start_a = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start_a = 1'b0;
        chk({t, "_done_seen"}, 32'(done_a), 32'd1);
        chk({t, "_busy_at_done"}, 32'(busy_a), 32'd0);
        chk({t, "_pass"}, 32'(pass_a), 32'(e.exp_pass));
        chk({t, "_timeout"}, 32'(to_a), 32'(e.exp_to));
        chk({t, "_err"}, 32'(err_a), 32'(e.exp_err));
        chk({t, "_fail_addr"}, faddr_a, e.exp_faddr);
        chk({t, "_fail_data"}, fdata_a, e.exp_fdata);
        chk({t, "_nreq"}, 32'(log_q.size()), 32'(e.exp_nreq));
        mism = 0;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            if (log_q[i].addr !== exp_q[i].addr || log_q[i].str !== exp_q[i].str ||
                (exp_q[i].str == 4'hF && log_q[i].data !== exp_q[i].data)) begin
                if (mism == 0)
                    $display("  %s first bad request %0d: addr %h str %h data %h, want %h %h %h", t, i,
                             log_q[i].addr, log_q[i].str, log_q[i].data,
                             exp_q[i].addr, exp_q[i].str, exp_q[i].data);
                mism++;
            end
        end
        chk({t, "_req_list"}, 32'(mism), 32'd0);
        chk({t, "_stable"}, 32'(stab_err), 32'd0);
        chk({t, "_gap"}, 32'(gap_err), 32'd0);
        if (e.hang >= 0) chk({t, "_valid_window"}, 32'(run_a), 32'(TO));
        @(posedge clk); #1;
        chk({t, "_done_pulse"}, 32'(done_a), 32'd0);
        chk({t, "_pass_hold"}, 32'(pass_a), 32'(e.exp_pass));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vt[7];

    initial begin : main
        int cyc;
        vt[0] = '{32'h0000_0000, 3, -1, -1, 0, 0, 1'b0, 1'b0, '0, '0, '0};
        vt[1] = '{32'hA5A5_A5A5, 3, 5, -1, 0, 0, 1'b0, 1'b0, '0, '0, '0};
        vt[2] = '{$urandom, 1, -1, 2, 0, 0, 1'b0, 1'b0, '0, '0, '0};
        vt[3] = '{$urandom, TO, -1, -1, 0, 0, 1'b0, 1'b0, '0, '0, '0};
        vt[4] = '{$urandom, int'($urandom_range(1, 4)), int'($urandom_range(0, 7)), -1, 0, 0,
                  1'b0, 1'b0, '0, '0, '0};
        vt[5] = '{$urandom, int'($urandom_range(1, 4)), -1, -1, 1, 0, 1'b0, 1'b0, '0, '0, '0};
        vt[6] = '{$urandom, int'($urandom_range(1, 4)), -1, int'($urandom_range(0, 31)), 0, 0,
                  1'b0, 1'b0, '0, '0, '0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus_a.o_sys_data_valid), 32'd0);
        chk("rst_addr", bus_a.o_sys_addr, 32'd0);
        chk("rst_str", 32'(bus_a.o_sys_write_str), 32'd0);
        chk("rst_wdata", bus_a.o_sys_data_to_sdram, 32'd0);
        chk("rst_flags", 32'({busy_a, done_a, pass_a, to_a}), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_fail", faddr_a | fdata_a, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_test(i, vt[i]);
            if (i == 0) begin
                chk("w2_addr", log_q[2].addr, 32'h0000_0008);
                chk("w2_data", log_q[2].data, 32'h0002_FFFD);
            end
        end

        // Reset in the middle of a read, after an error has already been recorded.
        lat_a = 2; hang_a = -1; corrupt_en = 1'b1; corrupt_addr = 32'h14;
        served_a = 0; log_q.delete(); mem_a.delete();
        @(posedge clk); #1;
        seed_a = $urandom; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        while (!(bus_a.o_sys_data_valid && bus_a.o_sys_write_str == 4'h0 &&
                 bus_a.o_sys_addr == 32'h18) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("midrd_found", 32'(cyc < 2000), 32'd1);
        chk("midrd_err_before", 32'(err_a), 32'd1);
        chk("midrd_faddr_before", faddr_a, 32'h14);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrd_valid", 32'(bus_a.o_sys_data_valid), 32'd0);
        chk("midrd_flags", 32'({busy_a, done_a, pass_a, to_a}), 32'd0);
        chk("midrd_err", 32'(err_a), 32'd0);
        chk("midrd_fail", faddr_a | fdata_a, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single-word region at the top of the address space.
        served_b = 0; addr_err_b = 0;
        seed_b = $urandom; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b_done_seen", 32'(done_b), 32'd1);
        chk("b_nreq", 32'(served_b), 32'd4);
        chk("b_addr", 32'(addr_err_b), 32'd0);
        chk("b_pass", 32'(pass_b), 32'd1);
        chk("b_err_to", 32'({err_b, to_b}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
